// File: rtl/game_pkg.sv
// Shared game definitions: FSM state encodings, round phase encoding, round defaults.
// Latency: none (types, constants and pure functions only).
// Backpressure: none.
package game_pkg;

   // Game FSM state encodings; the game FSM uses the same values.
   typedef enum logic [2:0] {
      MENU  = 3'd0,
      GAME  = 3'd1,
      P1WIN = 3'd2,
      P2WIN = 3'd3,
      TIE   = 3'd4,
      POINT = 3'd5
   } game_state_t;

   // Round phase as tracked by round_status_unit.
   typedef enum logic [1:0] {
      PH_IDLE   = 2'd0,
      PH_RUN    = 2'd1,
      PH_FROZEN = 2'd2
   } phase_t;

   localparam int DEF_MAX_HP     = 100;
   localparam int DEF_ROUND_SECS = 60;

   // Split a 0..99 value into BCD digits.
   function automatic logic [3:0] bcd_tens(input int v);
      return 4'(v / 10);
   endfunction

   function automatic logic [3:0] bcd_ones(input int v);
      return 4'(v % 10);
   endfunction

endpackage

// File: rtl/bcd_down_counter.sv
// Two-digit BCD down counter with synchronous load and hold at 00.
// Latency: load/decrement visible one cycle after the enabling edge.
// Backpressure: none; en is ignored while the count is 00.
// Ports: clk, rst (async, active-high), load + load_tens/load_ones,
//        en (decrement request), tens/ones (current digits), zero (count is 00).
module bcd_down_counter #(
   parameter logic [3:0] RST_TENS = 4'd6,
   parameter logic [3:0] RST_ONES = 4'd0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       load,
   input  logic [3:0] load_tens,
   input  logic [3:0] load_ones,
   input  logic       en,
   output logic [3:0] tens,
   output logic [3:0] ones,
   output logic       zero
);

   assign zero = (tens == 4'd0) && (ones == 4'd0);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tens <= RST_TENS;
         ones <= RST_ONES;
      end else if (load) begin
         tens <= load_tens;
         ones <= load_ones;
      end else if (en && !zero) begin
         if (ones != 4'd0) begin
            ones <= ones - 4'd1;
         end else begin
            ones <= 4'd9;
            tens <= tens - 4'd1;
         end
      end
   end

endmodule

// File: rtl/round_status_unit.sv
// Per-round status for the game FSM: both players' HP and the BCD countdown.
// Latency: HP/timer update one cycle after sampling; round entry values bypass combinationally.
// Backpressure: none; hits during invulnerability are dropped, inputs ignored outside RUN.
// Ports: clk16, rst (async, active-high), state (game FSM state), one_sec_pulse,
//        p1/p2 damage valid+amount; outputs p1HP, p2HP, BCD1:BCD0, round_start, frozen.
module round_status_unit
   import game_pkg::*;
#(
   parameter int MAX_HP     = DEF_MAX_HP,
   parameter int ROUND_SECS = DEF_ROUND_SECS,
   parameter int INVULN_CYC = 8
) (
   input  logic       clk16,
   input  logic       rst,
   input  logic [2:0] state,
   input  logic       one_sec_pulse,
   input  logic       p1_dmg_valid,
   input  logic [7:0] p1_dmg,
   input  logic       p2_dmg_valid,
   input  logic [7:0] p2_dmg,
   output logic [7:0] p1HP,
   output logic [7:0] p2HP,
   output logic [3:0] BCD1,
   output logic [3:0] BCD0,
   output logic       round_start,
   output logic       frozen
);

   localparam logic [7:0] HP_INIT  = 8'(MAX_HP);
   localparam logic [7:0] INV_INIT = 8'(INVULN_CYC);
   localparam logic [3:0] T_TENS   = bcd_tens(ROUND_SECS);
   localparam logic [3:0] T_ONES   = bcd_ones(ROUND_SECS);

   logic [2:0]      prev_state;
   logic            entry;
   phase_t          phase_q, phase_d;
   logic            run;
   logic [1:0]      hit_vld;
   logic [1:0][7:0] hit_amt;
   logic [1:0][7:0] hp_all;
   logic            hp_zero;
   logic [3:0]      t_tens, t_ones;
   logic            t_zero;

   // ---------------- round entry detection ----------------
   always_ff @(posedge clk16 or posedge rst) begin
      if (rst) prev_state <= MENU;
      else     prev_state <= state;
   end

   assign entry       = (state == GAME) && (prev_state != GAME);
   assign round_start = entry;

   // ---------------- phase FSM ----------------
   always_ff @(posedge clk16 or posedge rst) begin
      if (rst) phase_q <= PH_IDLE;
      else     phase_q <= phase_d;
   end

   always_comb begin
      phase_d = phase_q;
      case (phase_q)
         PH_IDLE:   if (entry) phase_d = PH_RUN;
         PH_RUN: begin
            if (state != GAME)        phase_d = PH_IDLE;
            else if (hp_zero || t_zero) phase_d = PH_FROZEN;
         end
         PH_FROZEN: if (state != GAME) phase_d = PH_IDLE;
         default:   phase_d = PH_IDLE;
      endcase
   end

   always_comb begin
      run    = 1'b0;
      frozen = 1'b0;
      case (phase_q)
         PH_RUN:    run    = 1'b1;
         PH_FROZEN: frozen = 1'b1;
         default: ;
      endcase
   end

   // ---------------- per-player HP and invulnerability ----------------
   assign hit_vld = {p2_dmg_valid, p1_dmg_valid};
   assign hit_amt = {p2_dmg, p1_dmg};

   for (genvar p = 0; p < 2; p++) begin : g_player
      logic [7:0] hp_q;
      logic [7:0] inv_q;

      // Entry cannot coincide with RUN, but it is checked first so a reload
      // always wins over any damage sampled on the same edge.
      always_ff @(posedge clk16 or posedge rst) begin
         if (rst) begin
            hp_q  <= HP_INIT;
            inv_q <= 8'd0;
         end else if (entry) begin
            hp_q  <= HP_INIT;
            inv_q <= 8'd0;
         end else if (run) begin
            if (hit_vld[p] && (inv_q == 8'd0)) begin
               hp_q  <= (hit_amt[p] >= hp_q) ? 8'd0 : hp_q - hit_amt[p];
               inv_q <= INV_INIT;
            end else if (inv_q != 8'd0) begin
               inv_q <= inv_q - 8'd1;
            end
         end
      end

      assign hp_all[p] = hp_q;
   end

   assign hp_zero = (hp_all[0] == 8'd0) || (hp_all[1] == 8'd0);

   // ---------------- round countdown ----------------
   bcd_down_counter #(
      .RST_TENS (T_TENS),
      .RST_ONES (T_ONES)
   ) u_timer (
      .clk       (clk16),
      .rst       (rst),
      .load      (entry),
      .load_tens (T_TENS),
      .load_ones (T_ONES),
      .en        (run && one_sec_pulse),
      .tens      (t_tens),
      .ones      (t_ones),
      .zero      (t_zero)
   );

   // The entry cycle shows the load values so the FSM never sees a stale
   // 0 HP or 00 timer left over from the previous round.
   assign p1HP = entry ? HP_INIT : hp_all[0];
   assign p2HP = entry ? HP_INIT : hp_all[1];
   assign BCD1 = entry ? T_TENS  : t_tens;
   assign BCD0 = entry ? T_ONES  : t_ones;

endmodule

// File: tb/tb_round_status_unit.sv
module tb_round_status_unit;

   localparam int MAXHP = 100;
   localparam int SECS  = 60;
   localparam int INV   = 8;

   logic       clk16 = 1'b0;
   logic       rst   = 1'b0;
   logic [2:0] state = 3'd0;
   logic       one_sec_pulse = 1'b0;
   logic       p1_dmg_valid  = 1'b0;
   logic [7:0] p1_dmg        = 8'd0;
   logic       p2_dmg_valid  = 1'b0;
   logic [7:0] p2_dmg        = 8'd0;
   logic [7:0] p1HP, p2HP;
   logic [3:0] BCD1, BCD0;
   logic       round_start, frozen;

   int checks = 0;
   int errors = 0;
   bit cmp_en = 1'b0;

   round_status_unit #(
      .MAX_HP     (MAXHP),
      .ROUND_SECS (SECS),
      .INVULN_CYC (INV)
   ) dut (
      .clk16         (clk16),
      .rst           (rst),
      .state         (state),
      .one_sec_pulse (one_sec_pulse),
      .p1_dmg_valid  (p1_dmg_valid),
      .p1_dmg        (p1_dmg),
      .p2_dmg_valid  (p2_dmg_valid),
      .p2_dmg        (p2_dmg),
      .p1HP          (p1HP),
      .p2HP          (p2HP),
      .BCD1          (BCD1),
      .BCD0          (BCD0),
      .round_start   (round_start),
      .frozen        (frozen)
   );

   always #5 clk16 = ~clk16;

   // ---------------- behavioural model ----------------
   // Round status: 0 = no round, 1 = playing, 2 = outcome decided.
   int m_prev  = 0;
   int m_mode  = 0;
   int m_secs  = SECS;
   int m_hp[2]  = '{MAXHP, MAXHP};
   int m_inv[2] = '{0, 0};
   logic m_entry, m_dead;

   assign m_entry = (state == 3'd1) && (m_prev != 1);
   assign m_dead  = (m_hp[0] == 0) || (m_hp[1] == 0) || (m_secs == 0);

   function automatic int after_hit(input int hp, input int dmg);
      return (dmg >= hp) ? 0 : hp - dmg;
   endfunction

   always @(posedge clk16 or posedge rst) begin
      if (rst) begin
         m_prev <= 0;
         m_mode <= 0;
         m_secs <= SECS;
         for (int p = 0; p < 2; p++) begin
            m_hp[p]  <= MAXHP;
            m_inv[p] <= 0;
         end
      end else begin
         if (m_entry) begin
            m_secs <= SECS;
            for (int p = 0; p < 2; p++) begin
               m_hp[p]  <= MAXHP;
               m_inv[p] <= 0;
            end
         end else if (m_mode == 1) begin
            for (int p = 0; p < 2; p++) begin
               if (((p == 0) ? p1_dmg_valid : p2_dmg_valid) && m_inv[p] == 0) begin
                  m_hp[p]  <= after_hit(m_hp[p], (p == 0) ? int'(p1_dmg) : int'(p2_dmg));
                  m_inv[p] <= INV;
               end else if (m_inv[p] > 0) begin
                  m_inv[p] <= m_inv[p] - 1;
               end
            end
            if (one_sec_pulse && m_secs > 0) m_secs <= m_secs - 1;
         end
         if (state != 3'd1)                m_mode <= 0;
         else if (m_mode == 0 && m_entry)  m_mode <= 1;
         else if (m_mode == 1 && m_dead)   m_mode <= 2;
         m_prev <= int'(state);
      end
   end

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
      end
   endtask

   // Compare process: every cycle, outputs against the model.
   always @(negedge clk16) begin
      if (cmp_en) begin
         chk("model_p1HP", p1HP, m_entry ? MAXHP : m_hp[0]);
         chk("model_p2HP", p2HP, m_entry ? MAXHP : m_hp[1]);
         chk("model_BCD1", BCD1, (m_entry ? SECS : m_secs) / 10);
         chk("model_BCD0", BCD0, (m_entry ? SECS : m_secs) % 10);
         chk("model_round_start", round_start, m_entry ? 1 : 0);
         chk("model_frozen", frozen, (m_mode == 2) ? 1 : 0);
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic cyc();
      @(posedge clk16);
      #1;
   endtask

   task automatic lwait();
      @(negedge clk16);
      #1;
   endtask

   task automatic drive(input int st, input bit v1, input int d1,
                        input bit v2, input int d2, input bit tick);
      state         = 3'(st);
      p1_dmg_valid  = v1;
      p1_dmg        = 8'(d1);
      p2_dmg_valid  = v2;
      p2_dmg        = 8'(d2);
      one_sec_pulse = tick;
   endtask

   task automatic lchk_out(input string nm, input int h1, input int h2,
                           input int b1, input int b0);
      chk({nm, "_p1HP"}, p1HP, h1);
      chk({nm, "_p2HP"}, p2HP, h2);
      chk({nm, "_BCD1"}, BCD1, b1);
      chk({nm, "_BCD0"}, BCD0, b0);
   endtask

   initial begin
      drive(0, 0, 0, 0, 0, 0);
      #1 rst = 1'b1;
      cmp_en = 1'b1;
      #2;
      lchk_out("reset", 100, 100, 6, 0);
      chk("reset_frozen", frozen, 0);
      chk("reset_round_start", round_start, 0);
      lwait();
      rst = 1'b0;
      cyc();

      // Round entry with bypassed load values.
      drive(1, 0, 0, 0, 0, 0);
      lwait();
      chk("entry_round_start", round_start, 1);
      lchk_out("entry", 100, 100, 6, 0);
      cyc();

      // Bring P1 to 30, wait out invulnerability.
      drive(1, 1, 70, 0, 0, 0);
      cyc();
      drive(1, 0, 0, 0, 0, 0);
      lwait();
      chk("p1_at_30", p1HP, 30);
      chk("round_start_low", round_start, 0);
      repeat (8) cyc();

      drive(1, 1, 12, 0, 0, 0);
      cyc();
      for (int k = 1; k <= 8; k++) begin
         drive(1, 1, 20, 0, 0, 0);
         lwait();
         chk("p1_hit_dropped", p1HP, 18);
         cyc();
      end
      drive(1, 1, 40, 0, 0, 0);
      cyc();
      drive(1, 0, 0, 0, 0, 0);
      lwait();
      chk("p1_ko_hp", p1HP, 0);
      chk("p1_ko_not_yet_frozen", frozen, 0);
      cyc();
      lwait();
      chk("p1_ko_frozen", frozen, 1);
      cyc();

      // Result screen: everything holds, damage and ticks ignored.
      for (int k = 0; k < 100; k++) begin
         drive(3, $urandom_range(0, 1) != 0, $urandom_range(0, 255),
               $urandom_range(0, 1) != 0, $urandom_range(0, 255), $urandom_range(0, 1) != 0);
         cyc();
      end
      lwait();
      lchk_out("hold", 0, 100, 6, 0);
      chk("hold_frozen", frozen, 0);
      cyc();

      drive(1, 0, 0, 0, 0, 0);
      lwait();
      chk("reload_round_start", round_start, 1);
      lchk_out("reload", 100, 100, 6, 0);
      cyc();

      // Countdown from 6:0.
      for (int i = 0; i < 59; i++) begin
         drive(1, 0, 0, 0, 0, 1);
         cyc();
         drive(1, 0, 0, 0, 0, 0);
         cyc();
         if (i == 0) begin
            lwait();
            chk("tick1_BCD1", BCD1, 5);
            chk("tick1_BCD0", BCD0, 9);
         end
      end
      lwait();
      chk("tick59_BCD1", BCD1, 0);
      chk("tick59_BCD0", BCD0, 1);
      drive(1, 0, 0, 0, 0, 1);
      cyc();
      lwait();
      lchk_out("timeout", 100, 100, 0, 0);
      chk("timeout_not_yet_frozen", frozen, 0);
      cyc();
      lwait();
      lchk_out("timeout_hold", 100, 100, 0, 0);
      chk("timeout_frozen", frozen, 1);
      cyc();

      // Leave and re-enter GAME on consecutive cycles; same-cycle events.
      drive(0, 0, 0, 0, 0, 0);
      cyc();
      drive(1, 0, 0, 0, 0, 0);
      lwait();
      chk("reenter_round_start", round_start, 1);
      cyc();
      drive(1, 1, 95, 1, 95, 0);
      cyc();
      drive(1, 0, 0, 0, 0, 0);
      lwait();
      chk("both_at5_p1", p1HP, 5);
      chk("both_at5_p2", p2HP, 5);
      repeat (8) cyc();
      drive(1, 1, 5, 1, 5, 1);
      cyc();
      drive(1, 0, 0, 0, 0, 0);
      lwait();
      lchk_out("double_ko", 0, 0, 5, 9);
      chk("double_ko_not_yet_frozen", frozen, 0);
      cyc();
      lwait();
      chk("double_ko_frozen", frozen, 1);
      cyc();

      // Mid-round reset at 42/77, 3:1.
      drive(0, 0, 0, 0, 0, 0);
      cyc();
      drive(1, 0, 0, 0, 0, 0);
      cyc();
      drive(1, 1, 58, 1, 23, 0);
      cyc();
      for (int i = 0; i < 29; i++) begin
         drive(1, 0, 0, 0, 0, 1);
         cyc();
         drive(1, 0, 0, 0, 0, 0);
         cyc();
      end
      lwait();
      lchk_out("pre_reset", 42, 77, 3, 1);
      chk("pre_reset_frozen", frozen, 0);
      #2 rst = 1'b1;
      #1;
      lchk_out("async_reset", 100, 100, 6, 0);
      chk("async_reset_frozen", frozen, 0);
      repeat (2) cyc();
      lwait();
      rst = 1'b0;
      #1;
      chk("post_reset_entry", round_start, 1);
      cyc();
      lwait();
      chk("post_reset_round_start_low", round_start, 0);
      cyc();

      // Randomized play.
      for (int k = 0; k < 4000; k++) begin
         int st;
         st = int'(state);
         if (st == 1) begin
            if ($urandom_range(0, 59) == 0) st = $urandom_range(0, 5);
         end else if ($urandom_range(0, 3) == 0) begin
            st = 1;
         end
         drive(st,
               $urandom_range(0, 5) == 0, ($urandom_range(0, 15) == 0) ? 255 : $urandom_range(0, 40),
               $urandom_range(0, 5) == 0, ($urandom_range(0, 15) == 0) ? 255 : $urandom_range(0, 40),
               $urandom_range(0, 2) == 0);
         cyc();
      end

      @(negedge clk16);
      cmp_en = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
